// File: rtl/image_stream_source.sv
// Self-scanning framebuffer image source: streams a WIDTH x HEIGHT frame in raster order
// over valid/ready with start-of-frame / end-of-line markers, single-shot or continuous.
module image_stream_source #(
  parameter int WIDTH  = 390,
  parameter int HEIGHT = 80,
  parameter int BPP    = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en,
  input  logic [$clog2(WIDTH*HEIGHT)-1:0]   wr_addr,
  input  logic [BPP-1:0]                    wr_data,
  input  logic                              enable,
  input  logic                              continuous,
  output logic                              pix_valid,
  input  logic                              pix_ready,
  output logic                              pix_r,
  output logic                              pix_g,
  output logic                              pix_b,
  output logic [$clog2(HEIGHT)-1:0]         pix_row,
  output logic [$clog2(WIDTH)-1:0]          pix_col,
  output logic                              pix_sof,
  output logic                              pix_eol,
  output logic                              frame_done,
  output logic                              busy
);

  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int AW    = $clog2(DEPTH);
  localparam int RW    = $clog2(HEIGHT);
  localparam int CW    = $clog2(WIDTH);

  // state    | meaning
  // S_IDLE   | output empty, scan counters parked at (0,0)
  // S_STREAM | loading pixels into the output register while enabled
  typedef enum logic {S_IDLE = 1'b0, S_STREAM = 1'b1} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [BPP-1:0]  r_fb [0:DEPTH-1];
  logic [RW-1:0]   r_row;
  logic [CW-1:0]   r_col;
  logic            r_valid;
  logic [BPP-1:0]  r_pix;
  logic [RW-1:0]   r_orow;
  logic [CW-1:0]   r_ocol;
  logic            r_sof;
  logic            r_eol;
  logic            r_frame_done;
  logic [AW-1:0]   w_rd_addr;
  logic [BPP-1:0]  w_rd_pix;
  logic            w_accept;
  logic            w_last_out;
  logic            w_load;
  logic            w_go_idle;
  logic            w_busy;

  // Framebuffer: not reset, out-of-range writes dropped, read is combinational
  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < (AW+1)'(DEPTH))) begin
      r_fb[wr_addr] <= wr_data;
    end
  end

  assign w_rd_addr  = AW'(32'(r_row) * 32'(WIDTH) + 32'(r_col));
  assign w_rd_pix   = r_fb[w_rd_addr];
  assign w_accept   = r_valid && pix_ready;
  assign w_last_out = r_valid && (r_orow == RW'(HEIGHT-1)) && (r_ocol == CW'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (enable)    w_state_nxt = S_STREAM;
      S_STREAM: if (w_go_idle) w_state_nxt = S_IDLE;
      default:                 w_state_nxt = S_IDLE;
    endcase
  end

  // A held last pixel in single-shot mode must not pull in (0,0) of a new frame
  always_comb begin
    w_busy    = (r_state == S_STREAM);
    w_load    = w_busy && enable && (!r_valid || pix_ready) && !(w_last_out && !continuous);
    w_go_idle = w_busy && !w_load && (!r_valid || pix_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_row        <= '0;
      r_col        <= '0;
      r_valid      <= 1'b0;
      r_pix        <= '0;
      r_orow       <= '0;
      r_ocol       <= '0;
      r_sof        <= 1'b0;
      r_eol        <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_accept && w_last_out;
      if (w_load) begin
        r_valid <= 1'b1;
        r_pix   <= w_rd_pix;
        r_orow  <= r_row;
        r_ocol  <= r_col;
        r_sof   <= (r_row == '0) && (r_col == '0);
        r_eol   <= (r_col == CW'(WIDTH-1));
        if (r_col == CW'(WIDTH-1)) begin
          r_col <= '0;
          if (r_row == RW'(HEIGHT-1)) r_row <= '0;
          else                        r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
      if (w_go_idle) begin
        r_row <= '0;
        r_col <= '0;
      end
    end
  end

  generate
    if (BPP == 1) begin : g_mono
      assign pix_r = r_pix[0];
      assign pix_g = r_pix[0];
      assign pix_b = r_pix[0];
    end else begin : g_rgb
      assign pix_r = r_pix[2];
      assign pix_g = r_pix[1];
      assign pix_b = r_pix[0];
    end
  endgenerate

  assign pix_valid  = r_valid;
  assign pix_row    = r_orow;
  assign pix_col    = r_ocol;
  assign pix_sof    = r_sof;
  assign pix_eol    = r_eol;
  assign frame_done = r_frame_done;
  assign busy       = w_busy;

endmodule
